// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - playfield geometry, row type, clear-controller states and line score table
package tetris_pkg;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int CELL_W = 3;
  localparam int ROW_W  = COLS * CELL_W;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    FLASH,
    SCAN,
    FILL,
    SCORE,
    DONE
  } lcc_state_t;

  // Points for k rows cleared in one pass; anything beyond four scores like four.
  function automatic logic [3:0] LINE_SCORE(input logic [4:0] k);
    case (k)
      5'd0:    LINE_SCORE = 4'd0;
      5'd1:    LINE_SCORE = 4'd1;
      5'd2:    LINE_SCORE = 4'd3;
      5'd3:    LINE_SCORE = 4'd5;
      default: LINE_SCORE = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - a row is full when every cell is nonzero
module row_full_detect
  import tetris_pkg::*;
(
  input  row_t row,
  output logic full
);

  logic [COLS-1:0] occupied;

  for (genvar j = 0; j < COLS; j++) begin : g_cell
    assign occupied[j] = |row[j*CELL_W +: CELL_W];
  end

  assign full = &occupied;

endmodule

// File: rtl/line_clear_controller.sv
// rtl/line_clear_controller.sv - marks full rows, compacts the grid downward, zero-fills the top, scores
// Optional row flash before compaction is enabled with LINE_FLASH_EN.
module line_clear_controller
  import tetris_pkg::*;
#(
  parameter int SCORE_W      = 10,
  parameter int FLASH_FRAMES = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               score_clear,
  input  logic               frame_tick,
  output logic               busy,
  output logic               done,
  output logic [4:0]         grid_rd_row,
  input  row_t               grid_rd_data,
  output logic               grid_wr_en,
  output logic [4:0]         grid_wr_row,
  output row_t               grid_wr_data,
  output logic [2:0]         lines_cleared,
  output logic [SCORE_W-1:0] lines_total,
  output logic [SCORE_W-1:0] score,
  output logic [ROWS-1:0]    flash_mask
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  lcc_state_t state, state_next;

  logic [4:0]      cnt;
  logic [4:0]      dst;
  logic [4:0]      k;
  logic [4:0]      k_mark;
  logic [ROWS-1:0] full_mask;
  logic            full;

  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W:0]   total_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [SCORE_W-1:0] total_sat;

  row_full_detect u_full (
    .row  (grid_rd_data),
    .full (full)
  );

  assign k_mark    = k + {4'b0, full};
  assign score_sum = {1'b0, score} + (SCORE_W+1)'(LINE_SCORE(k));
  assign total_sum = {1'b0, lines_total} + (SCORE_W+1)'(k);
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  assign total_sat = total_sum[SCORE_W] ? '1 : total_sum[SCORE_W-1:0];

`ifdef LINE_FLASH_EN
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);
  logic [FC_W-1:0] fcnt;
  logic            flash_last;

  assign flash_last = frame_tick && (fcnt == FC_W'(FLASH_FRAMES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fcnt <= '0;
    end else if (state == MARK) begin
      fcnt <= '0;
    end else if (state == FLASH && frame_tick) begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  logic unused_flash;
  assign unused_flash = frame_tick ^ (FLASH_FRAMES == 0);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = MARK;
      MARK: begin
        if (cnt == '0) begin
          if (k_mark == '0) begin
            state_next = DONE;
          end else begin
`ifdef LINE_FLASH_EN
            state_next = FLASH;
`else
            state_next = SCAN;
`endif
          end
        end
      end
`ifdef LINE_FLASH_EN
      FLASH: if (flash_last) state_next = SCAN;
`endif
      SCAN:  if (cnt == '0) state_next = FILL;
      FILL:  if (dst == '0) state_next = SCORE;
      SCORE: state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE) && (state != DONE);
    done         = (state == DONE);
    grid_rd_row  = cnt;
    grid_wr_en   = 1'b0;
    grid_wr_row  = dst;
    grid_wr_data = '0;
    flash_mask   = '0;
    case (state)
      // Surviving rows slide down to dst; identical src/dst is skipped to avoid a redundant write.
      SCAN: begin
        if (!full_mask[cnt] && dst != cnt) begin
          grid_wr_en   = 1'b1;
          grid_wr_data = grid_rd_data;
        end
      end
      FILL: grid_wr_en = 1'b1;
`ifdef LINE_FLASH_EN
      FLASH: flash_mask = full_mask;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt           <= '0;
      dst           <= '0;
      k             <= '0;
      full_mask     <= '0;
      score         <= '0;
      lines_total   <= '0;
      lines_cleared <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= LAST_ROW;
            k         <= '0;
            full_mask <= '0;
          end
        end
        MARK: begin
          full_mask[cnt] <= full;
          k              <= k_mark;
          if (cnt == '0) begin
            cnt <= LAST_ROW;
            dst <= LAST_ROW;
            if (k_mark == '0) lines_cleared <= '0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        SCAN: begin
          if (!full_mask[cnt]) dst <= dst - 5'd1;
          cnt <= cnt - 5'd1;
        end
        FILL:  if (dst != '0) dst <= dst - 5'd1;
        SCORE: lines_cleared <= (k > 5'd7) ? 3'd7 : k[2:0];
        default: ;
      endcase

      // A clear landing on the SCORE cycle wins and discards that pass's add.
      if (score_clear) begin
        score       <= '0;
        lines_total <= '0;
      end else if (state == SCORE) begin
        score       <= score_sat;
        lines_total <= total_sat;
      end
    end
  end

endmodule

// File: tb/tb_line_clear_controller.sv
// tb/tb_line_clear_controller.sv - directed bench for line_clear_controller with a behavioural grid owner
module tb_line_clear_controller;
  import tetris_pkg::*;

`ifdef LINE_FLASH_EN
  localparam int FL = 8;
`else
  localparam int FL = 0;
`endif

  localparam row_t FULL_A = 30'h09249249;
  localparam row_t FULL_B = 30'h3FFFFFFF;
  localparam row_t NEAR   = 30'h3FFFFFF8;
  localparam row_t ROW_P  = 30'h00000007;
  localparam row_t ROW_B  = 30'h02345670;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        score_clear = 1'b0;
  logic        frame_tick = 1'b0;
  logic        busy, done, grid_wr_en;
  logic [4:0]  grid_rd_row, grid_wr_row;
  row_t        grid_rd_data, grid_wr_data;
  logic [2:0]  lines_cleared;
  logic [9:0]  lines_total, score;
  logic [19:0] flash_mask;

  row_t grid [ROWS];
  row_t exp_grid [ROWS];

  int checks = 0;
  int failures = 0;
  int done_at, wrs, bad;
  logic [19:0] fm21;

  line_clear_controller dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .start         (start),
    .score_clear   (score_clear),
    .frame_tick    (frame_tick),
    .busy          (busy),
    .done          (done),
    .grid_rd_row   (grid_rd_row),
    .grid_rd_data  (grid_rd_data),
    .grid_wr_en    (grid_wr_en),
    .grid_wr_row   (grid_wr_row),
    .grid_wr_data  (grid_wr_data),
    .lines_cleared (lines_cleared),
    .lines_total   (lines_total),
    .score         (score),
    .flash_mask    (flash_mask)
  );

  always #5 Clk = ~Clk;

  assign grid_rd_data = (grid_rd_row < 5'd20) ? grid[grid_rd_row] : '0;

  always @(posedge Clk) begin
    if (grid_wr_en && grid_wr_row < 5'd20) grid[grid_wr_row] <= grid_wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_grids();
    for (int r = 0; r < ROWS; r++) begin
      grid[r]     = '0;
      exp_grid[r] = '0;
    end
  endtask

  task automatic load_four_full();
    clear_grids();
    for (int r = 16; r < ROWS; r++) grid[r] = FULL_B;
  endtask

  task automatic count_bad_rows(output int n);
    n = 0;
    for (int r = 0; r < ROWS; r++) if (grid[r] !== exp_grid[r]) n++;
  endtask

  task automatic run_pass(input int clr_at, input int restart_at, output int d_at, output int w);
    d_at = -1;
    w = 0;
    fm21 = '0;
    frame_tick = (FL != 0);
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 200 && d_at < 0; n++) begin
      @(negedge Clk);
      if (grid_wr_en) w++;
      if (done) d_at = n;
      if (n == 21) fm21 = flash_mask;
      score_clear = (n == clr_at);
      start = (n == restart_at);
    end
    score_clear = 1'b0;
    start = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    clear_grids();
    repeat (3) @(negedge Clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wr_en", {31'b0, grid_wr_en}, 32'd0);
    check("rst_score", {22'b0, score}, 32'd0);
    check("rst_flash", {12'b0, flash_mask}, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Empty grid: no writes, done after the mark sweep.
    run_pass(-1, -1, done_at, wrs);
    check("empty_done_at", done_at, 32'd21);
    check("empty_writes", wrs, 32'd0);
    check("empty_score", {22'b0, score}, 32'd0);
    check("empty_lines", {29'b0, lines_cleared}, 32'd0);

    // Row 19 full, row 18 partial.
    clear_grids();
    grid[19] = FULL_A;
    grid[18] = ROW_P;
    exp_grid[19] = ROW_P;
    run_pass(-1, -1, done_at, wrs);
    count_bad_rows(bad);
    check("one_done_at", done_at, 32'(43 + FL));
    check("one_writes", wrs, 32'd20);
    check("one_grid", bad, 32'd0);
    check("one_score", {22'b0, score}, 32'd1);
    check("one_lines", {29'b0, lines_cleared}, 32'd1);
    check("one_flash", {12'b0, fm21}, (FL != 0) ? 32'h80000 : 32'd0);

    // Rows 19 and 17 full; row 18 is one cell short of full and must survive.
    clear_grids();
    grid[19] = FULL_B;
    grid[18] = NEAR;
    grid[17] = FULL_A;
    grid[16] = ROW_B;
    exp_grid[19] = NEAR;
    exp_grid[18] = ROW_B;
    run_pass(-1, -1, done_at, wrs);
    count_bad_rows(bad);
    check("two_done_at", done_at, 32'(44 + FL));
    check("two_writes", wrs, 32'd20);
    check("two_grid", bad, 32'd0);
    check("two_score", {22'b0, score}, 32'd4);
    check("two_total", {22'b0, lines_total}, 32'd3);
    check("two_lines", {29'b0, lines_cleared}, 32'd2);
    check("two_flash", {12'b0, fm21}, (FL != 0) ? 32'hA0000 : 32'd0);

    // Four bottom rows full, row 15 holds data.
    load_four_full();
    grid[15] = ROW_B;
    exp_grid[19] = ROW_B;
    run_pass(-1, -1, done_at, wrs);
    count_bad_rows(bad);
    check("four_done_at", done_at, 32'(46 + FL));
    check("four_writes", wrs, 32'd20);
    check("four_grid", bad, 32'd0);
    check("four_score", {22'b0, score}, 32'd12);
    check("four_lines", {29'b0, lines_cleared}, 32'd4);

    // Climb to 1020 with four-row passes, then saturate.
    for (int p = 0; p < 126; p++) begin
      load_four_full();
      run_pass(-1, -1, done_at, wrs);
    end
    check("pre_sat_score", {22'b0, score}, 32'd1020);
    check("pre_sat_total", {22'b0, lines_total}, 32'd511);
    load_four_full();
    run_pass(-1, -1, done_at, wrs);
    check("sat_score", {22'b0, score}, 32'd1023);
    check("sat_total", {22'b0, lines_total}, 32'd515);

    // Clear coinciding with SCORE wins; a start while busy is ignored.
    load_four_full();
    run_pass(45 + FL, 10, done_at, wrs);
    check("clr_done_at", done_at, 32'(46 + FL));
    check("clr_score", {22'b0, score}, 32'd0);
    check("clr_total", {22'b0, lines_total}, 32'd0);
    repeat (3) @(negedge Clk);
    check("restart_ignored", {31'b0, busy}, 32'd0);

    // Asynchronous reset while compacting.
    clear_grids();
    grid[19] = FULL_A;
    frame_tick = (FL != 0);
    @(negedge Clk);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    repeat (25 + FL) @(negedge Clk);
    check("scan_wr_en", {31'b0, grid_wr_en}, 32'd1);
    check("scan_busy", {31'b0, busy}, 32'd1);
    #1 Reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_wr_en", {31'b0, grid_wr_en}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    frame_tick = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
